pyramic_clk_div_gen: RTL
========================

Name: pyramic_clk_div_gen

Overview:
- Parametrised, runtime-reconfigurable clock-divider bank driven by the 50 MHz system reference.
- Produces NUM_CLOCKS phase-aligned divided clocks plus one-cycle rising-edge strobes, for use as sample, serial-bit and DMA pacing enables.
- Provides a PLL-style locked indication that drops on any reconfiguration and re-asserts after a realignment and warm-up period.
- Sits beside the fixed PLL: the PLL supplies base clocks, this block derives programmable slower rates without a new PLL build.

Parameters:
- NUM_CLOCKS, 4, number of independent divider channels (1..16).
- CNT_WIDTH, 16, width of divisor, high-time and phase fields and of per-channel counters.
- LOCK_DELAY, 16, number of warm-up cycles after alignment before locked asserts (>=1).
- DEF_DIV, 4, reset value of every channel divisor.
- DEF_HIGH, 2, reset value of every channel high time.
- DEF_PHASE, 0, reset value of every channel phase offset.

Ports:
- refclk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_wr  in  1  one-cycle write strobe into channel shadow registers.
- cfg_ch  in  4  target channel; values >= NUM_CLOCKS cause the write to be ignored.
- cfg_div  in  CNT_WIDTH  divisor in refclk cycles.
- cfg_high  in  CNT_WIDTH  high time in refclk cycles.
- cfg_phase  in  CNT_WIDTH  counter start value at alignment.
- cfg_apply  in  1  one-cycle strobe: commit shadow registers and realign all channels.
- outclk  out  NUM_CLOCKS  divided clocks, registered.
- outclk_rise  out  NUM_CLOCKS  one-cycle strobe on each 0->1 transition of outclk[i].
- locked  out  1  high only in the LOCKED state.
- busy  out  1  high in the ALIGN and WARMUP states.

Behaviour:
- Reset (rst high, synchronous):
  - shadow and active registers load DEF_DIV, DEF_HIGH and DEF_PHASE;
  - outclk, outclk_rise and locked are 0;
  - busy is 1; state is ALIGN; warm-up counter is 0.
- Effective values, computed when active registers load:
  - div_eff = max(div, 2);
  - high_eff = clamp(high, 1, div_eff-1);
  - phase_eff = phase if phase < div_eff, else 0.
- ALIGN state (exactly 1 cycle):
  - active registers load from shadow; cnt[i] loads phase_eff[i];
  - outclk and outclk_rise are forced to 0; next state is WARMUP with warm-up counter 0.
- WARMUP state:
  - counters run;
  - warm-up counter increments; after LOCK_DELAY cycles the next state is LOCKED.
- LOCKED state: counters run; locked is 1.
- Counter rule in WARMUP and LOCKED:
  - cnt[i] <= (cnt[i] == div_eff-1) ? 0 : cnt[i]+1;
  - outclk[i] <= (cnt[i] < high_eff), so outclk lags the counter by one cycle;
  - outclk_rise[i] <= (cnt[i] < high_eff) and !outclk[i].
- Resulting waveform:
  - period is div_eff cycles; high time is high_eff cycles;
  - all channels share a common alignment instant, offset by their phase values.
- cfg_wr:
  - updates only the shadow registers of cfg_ch;
  - running outputs and locked are unaffected until cfg_apply.
- cfg_apply in any state:
  - next state is ALIGN; locked drops on the next cycle.
  - cfg_apply during WARMUP restarts alignment and the warm-up count.
- cfg_wr and cfg_apply in the same cycle: the write lands in shadow first, so it is included in the commit.
- Repeated cfg_apply: each strobe restarts ALIGN; no pulse is lost or queued.
- Reset mid-operation: returns all registers to defaults, discarding any shadow writes.
- Counter wrap at 2^CNT_WIDTH-1 cannot occur, because div_eff is at most 2^CNT_WIDTH-1.

Test Plan:
- Reset release, defaults (div 4, high 2, phase 0), LOCK_DELAY=16:
  - busy=1 for 17 cycles after rst falls; locked=1 from cycle 18;
  - outclk[*] = 1100 repeating, identical on all channels;
  - outclk_rise pulses every 4 cycles, coincident with outclk rising.
- Write ch1 (div 10, high 3, phase 5), then cfg_apply:
  - locked=0 on the next cycle;
  - after warm-up, outclk[1] has period 10 and high time 3;
  - outclk[1] rises 5 cycles later than outclk[0] relative to alignment.
- Clamp cases on ch2:
  - div=0 gives period 2;
  - div=6, high=9 gives high time 5;
  - div=6, high=0 gives high time 1;
  - div=6, phase=7 behaves as phase 0.
- cfg_wr to ch0 only, no apply: outputs and locked are unchanged for 100 cycles.
- cfg_wr with cfg_ch=15 (NUM_CLOCKS=4), then apply: all channels keep their prior settings.
- Reconfiguration timing and reset:
  - cfg_apply in WARMUP cycle 8: locked is delayed a further full LOCK_DELAY from the new ALIGN.
  - cfg_wr and cfg_apply in the same cycle: the new value is active after ALIGN.
  - rst pulse while LOCKED: all outputs are 0 next cycle and defaults are restored.

Source files
------------

// File: rtl/pyramic_clk_div_gen.sv
// Runtime-programmable divided-clock bank with shadowed config, common realignment and lock flag.
// Outputs registered one cycle behind the counters; no backpressure, cfg strobes always accepted.
module pyramic_clk_div_gen #(
  parameter int NUM_CLOCKS = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int LOCK_DELAY = 16,
  parameter int DEF_DIV    = 4,
  parameter int DEF_HIGH   = 2,
  parameter int DEF_PHASE  = 0
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [3:0]            cfg_ch,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  input  logic [CNT_WIDTH-1:0]  cfg_high,
  input  logic [CNT_WIDTH-1:0]  cfg_phase,
  input  logic                  cfg_apply,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_rise,
  output logic                  locked,
  output logic                  busy
);

  localparam int WW = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

  typedef enum logic [1:0] {ST_ALIGN, ST_WARMUP, ST_LOCKED} state_t;

  state_t               state;
  logic [WW-1:0]        warm_cnt;
  logic [CNT_WIDTH-1:0] sh_div   [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] sh_high  [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] sh_phase [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] act_div  [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] act_high [NUM_CLOCKS];
  logic [CNT_WIDTH-1:0] cnt      [NUM_CLOCKS];

  function automatic logic [CNT_WIDTH-1:0] eff_div(input logic [CNT_WIDTH-1:0] d);
    return (d < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : d;
  endfunction

  // de is already an effective divisor, so de-1 is at least 1
  function automatic logic [CNT_WIDTH-1:0] eff_high(input logic [CNT_WIDTH-1:0] h,
                                                    input logic [CNT_WIDTH-1:0] de);
    if (h == '0) return CNT_WIDTH'(1);
    if (h > de - CNT_WIDTH'(1)) return de - CNT_WIDTH'(1);
    return h;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] eff_phase(input logic [CNT_WIDTH-1:0] p,
                                                     input logic [CNT_WIDTH-1:0] de);
    return (p < de) ? p : '0;
  endfunction

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        sh_div[i]   <= CNT_WIDTH'(DEF_DIV);
        sh_high[i]  <= CNT_WIDTH'(DEF_HIGH);
        sh_phase[i] <= CNT_WIDTH'(DEF_PHASE);
        act_div[i]  <= eff_div(CNT_WIDTH'(DEF_DIV));
        act_high[i] <= eff_high(CNT_WIDTH'(DEF_HIGH), eff_div(CNT_WIDTH'(DEF_DIV)));
        cnt[i]      <= '0;
      end
      outclk      <= '0;
      outclk_rise <= '0;
      locked      <= 1'b0;
      busy        <= 1'b1;
      state       <= ST_ALIGN;
      warm_cnt    <= '0;
    end else begin
      // Out-of-range channel numbers match no entry and are dropped
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (cfg_wr && (cfg_ch == 4'(i))) begin
          sh_div[i]   <= cfg_div;
          sh_high[i]  <= cfg_high;
          sh_phase[i] <= cfg_phase;
        end
      end

      case (state)
        ST_ALIGN: begin
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            act_div[i]  <= eff_div(sh_div[i]);
            act_high[i] <= eff_high(sh_high[i], eff_div(sh_div[i]));
            cnt[i]      <= eff_phase(sh_phase[i], eff_div(sh_div[i]));
          end
          outclk      <= '0;
          outclk_rise <= '0;
          warm_cnt    <= '0;
          state       <= ST_WARMUP;
        end
        default: begin
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt[i]         <= (cnt[i] == act_div[i] - CNT_WIDTH'(1)) ? '0 : cnt[i] + CNT_WIDTH'(1);
            outclk[i]      <= (cnt[i] < act_high[i]);
            outclk_rise[i] <= (cnt[i] < act_high[i]) && !outclk[i];
          end
          if (state == ST_WARMUP) begin
            warm_cnt <= warm_cnt + 1'b1;
            if (warm_cnt == WW'(LOCK_DELAY - 1)) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
              busy   <= 1'b0;
            end
          end
        end
      endcase

      // Apply overrides every state transition above, including a pending lock
      if (cfg_apply) begin
        state  <= ST_ALIGN;
        locked <= 1'b0;
        busy   <= 1'b1;
      end
    end
  end

endmodule
